// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between EX/MEM and data memory, with
// youngest-match load forwarding so the MEM stage never reads stale data.
module store_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      memwrite_m,
    input  logic                      memread_m,
    input  logic [ADDR_WIDTH-1:0]     addr_m,
    input  logic [DATA_WIDTH-1:0]     wdata_m,
    input  logic                      mem_busy,
    output logic                      stall_m,
    output logic                      fwd_hit_m,
    output logic [DATA_WIDTH-1:0]     fwd_data_m,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]      ent_valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  full;
    logic                  store_req;
    logic                  do_push;
    logic                  do_pop;

    // Push/drain decisions and memory port arbitration; a load owns the port.
    always_comb begin
        full      = (count == FULL_CNT);
        store_req = memwrite_m & ~memread_m;
        stall_m   = ~rst & store_req & full;
        do_push   = ~rst & store_req & ~full;
        do_pop    = ~rst & ~memread_m & ~mem_busy & (count != '0);
        mem_we    = do_pop;
        mem_addr  = do_pop ? ent_addr[rd_ptr] : addr_m;
        mem_wdata = (count != '0) ? ent_data[rd_ptr] : '0;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Youngest-first search: walk backwards from wr_ptr in wrap order.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        found      = 1'b0;
        idx        = '0;
        fwd_data_m = '0;
        if (memread_m && !rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                idx = wr_ptr - PTR_W'(k + 1);
                if (!found && ent_valid[idx] && (ent_addr[idx] == addr_m)) begin
                    found      = 1'b1;
                    fwd_data_m = ent_data[idx];
                end
            end
        end
        fwd_hit_m = found;
    end

    // Queue state; reset discards pending stores without draining them.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            ent_valid <= '0;
        end else begin
            if (do_push) begin
                ent_addr[wr_ptr]  <= addr_m;
                ent_data[wr_ptr]  <= wdata_m;
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

endmodule
